result_display: RTL and testbench
=================================

# result_display

Downstream stage of the register-file/ALU top level: captures the 8-bit `result` on a load strobe and converts it to three BCD digits with a sequential double-dabble engine. It drives a multiplexed 4-digit common-anode seven-segment display with the unsigned decimal value (0–255). It is the last stage before the board pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Must be at least 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `load`  in  1  single-cycle strobe; capture `result` when the block is idle.
- `result`  in  8  unsigned value from the ALU stage.
- `busy`  out  1  high while a conversion is in progress.
- `bcd`  out  12  `{hundreds, tens, ones}`; registered, updated only at conversion end.
- `an`  out  4  digit anodes, active-low; `an[3]` is always 1.
- `seg`  out  7  cathodes, active-low, ordered `{g,f,e,d,c,b,a}`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `load`=1 → latch `result` into an 8-bit shift register.
  - Clear the 12-bit scratch register and set the iteration count to 0.
  - Go to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to each scratch nibble that is ≥5.
  - Shift `{scratch, shreg}` left by 1.
  - Increment the count.
  - After the 8th iteration go to DONE.
- DONE: copy scratch to `bcd`, then go to IDLE.
- `busy` = (state ≠ IDLE), registered.
- `load` while busy: ignored, not queued.
- `load` in the same cycle DONE→IDLE: ignored.
- Width rules:
  - Scratch nibbles never exceed 9 after a shift.
  - Maximum input 255 → `bcd` = 12'h255.
- Scan logic:
  - Refresh counter runs 0..REFRESH_DIV−1.
  - On wrap, the digit index advances 0→1→2→0. Index 0 = ones/`an[0]`, 1 = tens/`an[1]`, 2 = hundreds/`an[2]`.
  - `an` and `seg` are registered from the index and `bcd`.
  - The scan always shows the last completed `bcd`, never scratch.
- Segment encodings: standard 0–9. "0" = 7'b1000000, "1" = 7'b1111001, blank = 7'b1111111.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `bcd`=0.
  - Refresh counter 0, index 0.
  - `an`=4'b1111, `seg`=7'b1111111.
- `load` sampled at edge E:
  - `busy`=1 after E.
  - SHIFT occupies edges E+1..E+8.
  - DONE at edge E+9 updates `bcd`, with `busy`=0 after E+9.
- Latency: 9 cycles. Next `load` is accepted at edge E+10.
- First display refresh after reset: `an`=4'b1110 one cycle after reset deasserts.
- Each digit is active for exactly REFRESH_DIV cycles; the full frame is 3×REFRESH_DIV.
- A `bcd` update mid-digit appears on `seg` one cycle later, with no change of index.
- Reset mid-conversion:
  - Abort to IDLE with `busy`=0.
  - `bcd` clears to 0 and the scan restarts at index 0.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Hundreds digit blanked (`an[2]`=1, `seg` blank) when it is 0.
  - Tens digit blanked when both hundreds and tens are 0.
  - Ones digit is always shown.
  - Scan timing is unchanged; a blank digit still occupies its slot.
- Not defined: all three digits are always driven, including leading zeros.

## Structure
- `display_pkg` holds:
  - FSM state enum.
  - Digit count constant (3).
  - Seven-segment lookup constants for 0–9 and blank.
  - `BCD_W`=12.
- Sub-module `bin8_to_bcd`: the FSM and double-dabble datapath (`load`/`busy`/`bcd`).
- Top `result_display`: instantiates `bin8_to_bcd` and contains the refresh counter, digit mux and segment decode.

## Test plan
Bench runs with REFRESH_DIV=4.
- Conversion timing: `result`=8'd255, `load` pulse → `busy` high 9 cycles, then `bcd`=12'h255.
- Zero input: `result`=0 → `bcd`=12'h000.
- Mid-range: `result`=8'd100 → `bcd`=12'h100.
- Scan sequence: `an` cycles 1110, 1101, 1011 with 4 cycles each; `seg` shows 0, 0, 1 in turn.
- Load while busy: pulse `load` with 8'd200, then `load` with 8'd37 four cycles later → final `bcd`=12'h200; the second load is ignored.
- Reset mid-conversion: assert `rst` on cycle 5 of a conversion of 8'd99 → `busy`=0, `bcd`=0, `an`=4'b1111 next cycle; a new `load` of 8'd99 then yields 12'h099.
- Blanking:
  - With `LEADING_ZERO_BLANK_EN`: `result`=8'd7 → `an[2]` and `an[1]` stay 1 throughout the frame; `an[0]` slot shows 7 (7'b1111000).
  - Without the macro: the same input shows 0, 0, 7.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the result display path:
//               converter FSM state encoding, digit count, BCD width,
//               active-low seven-segment glyphs and small helper functions.
// Revision    : 1.0  initial release
// ============================================================================
package display_pkg;

    // Converter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DIGITS     = 3;
    localparam int BCD_W      = 12;
    localparam int SHIFT_ITER = 8;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyph lookup; anything outside 0-9 renders blank
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would exceed 9
    // after doubling, so pre-add 3 to carry into the next decade.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/bin8_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin8_to_bcd
// Description : Sequential 8-bit binary to 3-digit BCD converter using the
//               shift-and-add-3 (double-dabble) method, one bit per cycle.
//               Ports:
//                 clk    - system clock
//                 rst    - synchronous active-high reset
//                 load   - start strobe, honoured only while idle
//                 result - unsigned 8-bit value to convert
//                 busy   - high while a conversion is in flight
//                 bcd    - {hundreds, tens, ones}, updated at conversion end
// Revision    : 1.0  initial release
// ============================================================================
module bin8_to_bcd
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [7:0]       result,
    output logic             busy,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [2:0] LAST_ITER = 3'(SHIFT_ITER - 1);

    state_t           state;
    state_t           next_state;
    logic [7:0]       shreg;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] scratch_adj;
    logic [2:0]       count;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (load) next_state = ST_SHIFT;
            ST_SHIFT: if (count == LAST_ITER) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs: busy decodes straight from the state register, so it has
    // no combinational path from any input.
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Per-nibble correction applied before each shift
    always_comb begin
        scratch_adj = {dabble_adjust(scratch[11:8]),
                       dabble_adjust(scratch[7:4]),
                       dabble_adjust(scratch[3:0])};
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg   <= result;
                        scratch <= '0;
                        count   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // {scratch, shreg} shifted left by one after correction
                    scratch <= {scratch_adj[BCD_W-2:0], shreg[7]};
                    shreg   <= {shreg[6:0], 1'b0};
                    count   <= count + 3'd1;
                end
                ST_DONE: begin
                    bcd <= scratch;
                end
                default: ;
            endcase
        end
    end

endmodule : bin8_to_bcd
`default_nettype wire

// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module      : result_display
// Description : Captures the ALU result, converts it to BCD and scans it
//               onto a multiplexed 4-digit common-anode seven-segment
//               display (digit 3 unused, always dark).
//               Build option: define LEADING_ZERO_BLANK_EN to blank leading
//               zeros in the hundreds/tens positions.
//               Ports:
//                 clk    - system clock
//                 rst    - synchronous active-high reset
//                 load   - capture strobe for result
//                 result - unsigned 8-bit value from the ALU stage
//                 busy   - conversion in progress
//                 bcd    - last completed {hundreds, tens, ones}
//                 an     - digit anodes, active-low
//                 seg    - cathodes {g,f,e,d,c,b,a}, active-low
//               Parameter REFRESH_DIV: cycles each digit stays lit (>= 2).
// Revision    : 1.0  initial release
// ============================================================================
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [7:0]       result,
    output logic             busy,
    output logic [BCD_W-1:0] bcd,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int              CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       DIGIT_LAST = 2'(DIGITS - 1);

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic             refresh_wrap;
    logic [3:0]       digit_val;
    logic             digit_blank;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;

    bin8_to_bcd u_conv (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .result (result),
        .busy   (busy),
        .bcd    (bcd)
    );

    assign refresh_wrap = (refresh_cnt == CNT_MAX);

    // Digit select and optional leading-zero suppression. Only the
    // completed bcd register is ever shown, never the converter scratch.
    always_comb begin
        digit_val   = bcd[3:0];
        digit_blank = 1'b0;
        case (digit_idx)
            2'd0:    digit_val = bcd[3:0];
            2'd1:    digit_val = bcd[7:4];
            2'd2:    digit_val = bcd[11:8];
            default: digit_val = bcd[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_idx)
            2'd1:    digit_blank = (bcd[11:4] == 8'h00);
            2'd2:    digit_blank = (bcd[11:8] == 4'h0);
            default: digit_blank = 1'b0;
        endcase
`endif
        if (digit_blank) begin
            an_next  = 4'b1111;
            seg_next = SEG_BLANK;
        end else begin
            an_next  = ~(4'b0001 << digit_idx);
            seg_next = seg_of(digit_val);
        end
    end

    // Refresh counter, digit index and registered pin drivers. The pins
    // lag the index by one cycle, so every digit still gets exactly
    // REFRESH_DIV cycles on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_wrap) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == DIGIT_LAST) ? 2'd0 : (digit_idx + 2'd1);
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule : result_display
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_display
// Description : Directed self-checking bench for result_display with
//               REFRESH_DIV = 4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_result_display;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        load;
    logic [7:0]  result;
    logic        busy;
    logic [11:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .result (result),
        .busy   (busy),
        .bcd    (bcd),
        .an     (an),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs and samples both sit 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse load and follow the full 9-cycle conversion
    task automatic convert(input logic [7:0] val, input logic [11:0] exp_bcd, input string tag);
        result = val;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check({tag, "_busy_E"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check({tag, "_busy_shift"}, 32'(busy), 32'd1);
        end
        tick();
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    endtask

    int found;
    int c_ones, c_tens, c_hund, c_dark;

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        result = 8'd0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd",  32'(bcd),  32'h000);
        check("rst_an",   32'(an),   32'hF);
        check("rst_seg",  32'(seg),  32'h7F);

        rst = 1'b0;
        tick();
        check("first_an",  32'(an),  32'hE);
        check("first_seg", 32'(seg), 32'h40);

        convert(8'd255, 12'h255, "c255");
        convert(8'd0,   12'h000, "c0");
        convert(8'd100, 12'h100, "c100");

        // Align to the start of the ones slot, then walk one frame
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            logic [3:0] prev_an;
            prev_an = an;
            tick();
            if (an == 4'b1110 && prev_an != 4'b1110) found = 1;
        end
        check("scan_align", 32'(found), 32'd1);
        for (int i = 0; i < DIV; i++) begin
            if (i > 0) tick();
            check("scan_an0",  32'(an),  32'hE);
            check("scan_seg0", 32'(seg), 32'h40);
        end
        for (int i = 0; i < DIV; i++) begin
            tick();
            check("scan_an1",  32'(an),  32'hD);
            check("scan_seg1", 32'(seg), 32'h40);
        end
        for (int i = 0; i < DIV; i++) begin
            tick();
            check("scan_an2",  32'(an),  32'hB);
            check("scan_seg2", 32'(seg), 32'h79);
        end
        tick();
        check("scan_wrap_an", 32'(an), 32'hE);

        // Second load four cycles into a conversion must be dropped
        result = 8'd200;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        tick(); tick(); tick();
        result = 8'd37;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (busy == 1'b0) found = 1;
        end
        check("lwb_done",  32'(found), 32'd1);
        check("lwb_bcd",   32'(bcd),   32'h200);
        tick();
        check("lwb_noqueue", 32'(busy), 32'd0);

        // Reset on cycle 5 of a conversion
        result = 8'd99;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        tick(); tick(); tick(); tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bcd",  32'(bcd),  32'h000);
        check("mid_rst_an",   32'(an),   32'hF);
        rst = 1'b0;
        tick();
        check("mid_rst_an0", 32'(an), 32'hE);
        convert(8'd99, 12'h099, "c99");

        // Leading-zero behaviour over one full frame
        convert(8'd7, 12'h007, "c7");
        tick();
        c_ones = 0; c_tens = 0; c_hund = 0; c_dark = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (an == 4'b1110 && seg == 7'b1111000) c_ones++;
            if (an == 4'b1101 && seg == 7'b1000000) c_tens++;
            if (an == 4'b1011 && seg == 7'b1000000) c_hund++;
            if (an == 4'b1111 && seg == 7'b1111111) c_dark++;
`ifdef LEADING_ZERO_BLANK_EN
            check("blank_an21", 32'(an[2:1]), 32'h3);
`endif
            tick();
        end
        check("frame_ones", 32'(c_ones), 32'(DIV));
`ifdef LEADING_ZERO_BLANK_EN
        check("frame_tens", 32'(c_tens), 32'd0);
        check("frame_hund", 32'(c_hund), 32'd0);
        check("frame_dark", 32'(c_dark), 32'(2 * DIV));
`else
        check("frame_tens", 32'(c_tens), 32'(DIV));
        check("frame_hund", 32'(c_hund), 32'(DIV));
        check("frame_dark", 32'(c_dark), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_result_display
`default_nettype wire
